// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage RV32 pipeline.
// Handles load-use bubbles, taken-branch flushes and multicycle EX ops
// (start/done handshake with timeout).
// Keeps saturating stall/flush counters and a sticky timeout flag.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_mc_req,
  input  logic             ex_branch_taken,
  input  logic             mc_done,
  output logic             mc_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MC_TIMEOUT - 1);

  // The launch (MC_START) cycle is decoded combinationally while in RUN, so
  // only RUN and MC_WAIT need to be held in a register.
  typedef enum logic [0:0] {StRun, StMcWait} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mc_timeout_q, mc_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               load_use;
  logic               flush_ev;

  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                     (id_uses_rs2 && (ex_rd == id_rs2)));

  assign mc_timeout = mc_timeout_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  // Mealy pipeline controls and FSM next state.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mc_start     = 1'b0;
    flush_ev     = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mc_timeout_d = mc_timeout_q;

    unique case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          // Squashes the ID instruction, so any load-use stall is moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_ev    = 1'b1;
        end else if (ex_mc_req) begin
          mc_start     = 1'b1;
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          wait_cnt_d   = '0;
          state_d      = StMcWait;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      StMcWait: begin
        if (mc_done) begin
          state_d = StRun;
        end else begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          if (wait_cnt_q == WaitLast) begin
            // Give up on the unit; its result is dropped by the EX/MEM bubble.
            mc_timeout_d = 1'b1;
            state_d      = StRun;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
      end
    endcase

    // Hold the pipe quiet while reset is asserted, independent of the clock.
    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mc_start     = 1'b0;
    end
  end

  // Saturating performance counter next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_ev && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, wait counter, sticky flag and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StRun;
      wait_cnt_q   <= '0;
      mc_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      mc_timeout_q <= mc_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: per-cycle expected controls,
// counters and timeout flag are queued as stimulus is applied and popped
// at the falling edge, where the Mealy outputs are sampled.
module tb_hazard_stall_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned TO = 8;

  // {mc_start, pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush}
  localparam logic [6:0] DEF = 7'b0111000;
  localparam logic [6:0] LU  = 7'b0001010;
  localparam logic [6:0] BR  = 7'b0111110;
  localparam logic [6:0] MCL = 7'b1000001;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] RST = 7'b0000111;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       mc;
    logic       br;
    logic       dn;
    logic [6:0] ctl;
    logic       to_ev;
  } step_t;

  typedef struct packed {
    logic [6:0]    ctl;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
    logic          to;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic          ex_MemRead = 1'b0, ex_mc_req = 1'b0, ex_branch_taken = 1'b0, mc_done = 1'b0;
  logic          mc_start, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic          ex_mem_flush, mc_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctl_o;
  logic [15:0]   obs;

  exp_t          sb[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;
  logic          m_to = 1'b0;

  hazard_stall_ctrl #(.CNT_W(CW), .MC_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_mc_req(ex_mc_req),
    .ex_branch_taken(ex_branch_taken), .mc_done(mc_done),
    .mc_start(mc_start), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mc_timeout(mc_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl_o = {mc_start, pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
                  ex_mem_flush};
  assign obs   = {ctl_o, stall_cnt, flush_cnt, mc_timeout};

  always #5 clk = ~clk;

  function automatic step_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic [4:0] rd, input logic mr,
                               input logic mc, input logic br, input logic dn,
                               input logic [6:0] ctl, input logic to_ev);
    step_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd; s.mr = mr;
    s.mc = mc; s.br = br; s.dn = dn; s.ctl = ctl; s.to_ev = to_ev;
    return s;
  endfunction

  function automatic step_t idle(input logic [6:0] ctl);
    return mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, 1'b0);
  endfunction

  // Drive one cycle of inputs, queue its expectation, advance the reference counters.
  task automatic apply(input step_t s);
    exp_t x;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
    ex_rd = s.rd; ex_MemRead = s.mr; ex_mc_req = s.mc; ex_branch_taken = s.br;
    mc_done = s.dn;
    x.ctl = s.ctl; x.stall = m_stall; x.flush = m_flush; x.to = m_to;
    sb.push_back(x);
    if (!s.ctl[5] && (m_stall != '1)) m_stall = m_stall + 1'b1;
    if ((s.ctl == BR) && (m_flush != '1)) m_flush = m_flush + 1'b1;
    if (s.to_ev) m_to = 1'b1;
  endtask

  task automatic test_reset();
    exp_t x;
    step_t q[$];
    reset_n = 1'b0;
    apply(idle(RST));
    void'(sb.pop_back());
    x.ctl = RST; x.stall = '0; x.flush = '0; x.to = 1'b0;
    sb.push_back(x);
    m_stall = '0; m_flush = '0; m_to = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs, e);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(idle(DEF));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_idle[%0d] got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    step_t q[$];
    q.push_back(mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0));
    q.push_back(idle(DEF));
    q.push_back(mk(5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0));
    q.push_back(mk(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0));
    q.push_back(idle(DEF));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_use[%0d] got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_no_stall();
    step_t q[$];
    q.push_back(mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEF, 1'b0));
    q.push_back(mk(5'd9, 5'd4, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, DEF, 1'b0));
    q.push_back(mk(5'd6, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, DEF, 1'b0));
    q.push_back(mk(5'd11, 5'd12, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, DEF, 1'b0));
    q.push_back(mk(5'd4, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, DEF, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL no_stall[%0d] got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    step_t q[$];
    q.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, BR, 1'b0));
    q.push_back(idle(DEF));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BR, 1'b0));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BR, 1'b0));
    q.push_back(mk(5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0));
    q.push_back(idle(DEF));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL branch[%0d] got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multicycle();
    step_t q[$];
    step_t mcw;
    mcw = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 1'b0);
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCL, 1'b0));
    for (int k = 0; k < 3; k++) q.push_back(mcw);
    // Load-use inputs during the wait must not change the freeze pattern.
    q.push_back(mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, FRZ, 1'b0));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, DEF, 1'b0));
    q.push_back(idle(DEF));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF, 1'b0));
    // Back-to-back multicycle ops.
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCL, 1'b0));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, DEF, 1'b0));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCL, 1'b0));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, DEF, 1'b0));
    q.push_back(idle(DEF));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL multicycle[%0d] got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t q[$];
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCL, 1'b0));
    for (int k = 0; k < TO; k++) begin
      q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,
                     (k == TO - 1) ? 1'b1 : 1'b0));
    end
    q.push_back(idle(DEF));
    q.push_back(mk(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCL, 1'b0));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, DEF, 1'b0));
    q.push_back(idle(DEF));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout[%0d] got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    step_t q[$];
    step_t r[$];
    exp_t x;
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MCL, 1'b0));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 1'b0));
    q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rst_wait_pre[%0d] got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
    // Assert reset between clock edges; everything must react without a clock.
    ex_mc_req = 1'b0;
    reset_n = 1'b0;
    m_stall = '0; m_flush = '0; m_to = 1'b0;
    x.ctl = RST; x.stall = '0; x.flush = '0; x.to = 1'b0;
    sb.push_back(x);
    #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rst_wait_async got %b want %b", obs, e);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    r.push_back(idle(DEF));
    r.push_back(mk(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0));
    r.push_back(idle(DEF));
    foreach (r[i]) begin
      apply(r[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rst_wait_post[%0d] got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    step_t q[$];
    for (int k = 0; k < 18; k++) begin
      q.push_back(mk(5'd0, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0));
    end
    for (int k = 0; k < 18; k++) begin
      q.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BR, 1'b0));
    end
    q.push_back(idle(DEF));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL saturation[%0d] got %b want %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_multicycle();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
